inst_seq: RTL and testbench
===========================

INST_SEQ -- requirements
Module: inst_seq

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the program counter value loaded at reset.
REQ-002 SHALL have parameter TIMEOUT, default 15 (range 1..15), meaning the maximum wait cycles for a memory ready before trapping.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-005 SHALL have port imem_rdata, input, 32 bits, the fetched instruction word.
REQ-006 SHALL have port imem_ready, input, 1 bit, instruction memory data valid.
REQ-007 SHALL have port dmem_ready, input, 1 bit, data memory access complete.
REQ-008 SHALL have port imem_req, output, 1 bit, instruction fetch request.
REQ-009 SHALL have port dmem_req, output, 1 bit, data memory request.
REQ-010 SHALL have port dmem_we, output, 1 bit, data memory write (store) qualifier.
REQ-011 SHALL have port reg_we, output, 1 bit, register-file write strobe.
REQ-012 SHALL have port link_we, output, 1 bit, link-register write strobe.
REQ-013 SHALL have port link_data, output, 32 bits, return address for branch-and-link.
REQ-014 SHALL have port pc, output, 32 bits, current instruction address.
REQ-015 SHALL have port ir, output, 32 bits, latched instruction.
REQ-016 SHALL have port instype, output, 2 bits: 1 data, 2 memory, 3 branch, 0 undefined.
REQ-017 SHALL have port state, output, 3 bits, current FSM state.
REQ-018 SHALL have port halted, output, 1 bit, high while in TRAP.
REQ-019 SHALL have port timeout_err, output, 1 bit, high while in TRAP if entry was caused by timeout.

Function
REQ-020 SHALL implement the FSM states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6 and 7 SHALL go to TRAP on the next edge.
REQ-021 In FETCH, imem_req SHALL be 1; on imem_ready=1 the FSM SHALL latch ir<=imem_rdata and go to DECODE, else it stays in FETCH.
REQ-022 In DECODE (one cycle), instype SHALL be registered from ir[27:26]: 00->1, 01->2, 10->3, 11->0; the FSM SHALL go to TRAP if ir[27:26]=11, else to EXEC.
REQ-023 In EXEC with instype=1, the FSM SHALL go to WB.
REQ-024 In EXEC with instype=2, the FSM SHALL go to MEM.
REQ-025 In EXEC with instype=3, on leaving EXEC pc SHALL become pc+8+sign_extend({ir[23:0],2'b00}) mod 2^32 and the FSM SHALL go to FETCH.
REQ-026 In EXEC with instype=3 and ir[24]=1, link_we SHALL be 1 for exactly that cycle with link_data=pc+4 (pre-update pc).
REQ-027 In MEM, dmem_req SHALL be 1 and dmem_we SHALL equal ~ir[20]; on dmem_ready=1 a load (ir[20]=1) SHALL go to WB, and a store SHALL set pc<=pc+4 and go to FETCH.
REQ-028 In WB, reg_we SHALL be 1 for exactly one cycle, pc SHALL become pc+4 (wrapping at 2^32), and the FSM SHALL go to FETCH.
REQ-029 A 4-bit wait counter SHALL clear on entry to FETCH or MEM and increment each cycle a request is high with ready low.
REQ-030 When the wait counter equals TIMEOUT and ready is still low, the FSM SHALL go to TRAP with timeout_err=1; ready high in that same cycle SHALL win (normal progress).
REQ-031 TRAP SHALL be absorbing (exit only by reset); in TRAP halted=1 and all request/strobe outputs SHALL be 0.
REQ-032 imem_req, dmem_req, dmem_we, reg_we and link_we SHALL be 0 in every state not named for them above.
REQ-033 Outputs SHALL be glitch-free Moore decodes of registered state and ir.

Reset
REQ-034 While rst_n=0, regardless of clk: state=FETCH, pc=RESET_PC, ir=0, instype=0, wait counter=0, link_data=0, and all 1-bit outputs SHALL be 0 (imem_req gated by rst_n).
REQ-035 A reset asserted mid-access SHALL abandon the access with no strobe issued; fetch SHALL restart at RESET_PC on the first edge after rst_n rises.

Verification
REQ-036 The bench SHALL cover: data op 32'hE0812003 fetched at pc=0 with imem_ready=1 -> DECODE, EXEC, WB; reg_we pulse in WB; pc=4; 4 clocks per instruction.
REQ-037 The bench SHALL cover: load 32'hE5912000 with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, reg_we pulse, pc+=4.
REQ-038 The bench SHALL cover: store 32'hE5812000 -> dmem_we=1 during MEM, no reg_we, return to FETCH with pc+=4.
REQ-039 The bench SHALL cover: BL 32'hEBFFFFFE at pc=0x100 -> link_we pulse with link_data=0x104, next pc=0x100.
REQ-040 The bench SHALL cover: undefined 32'hEC000000 -> TRAP, halted=1, timeout_err=0; imem_ready never high -> TRAP after TIMEOUT+1 FETCH cycles with timeout_err=1.
REQ-041 The bench SHALL cover: rst_n pulsed low during MEM -> outputs reset immediately, then imem_req=1 with pc=RESET_PC.

Source files
------------

// File: rtl/inst_seq.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with a TRAP sink
// for undefined opcodes and memory handshakes that exceed TIMEOUT wait cycles.
module inst_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_we,
  output logic        link_we,
  output logic [31:0] link_data,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [1:0]  instype,
  output logic [2:0]  state,
  output logic        halted,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [3:0] TIMEOUT_L = 4'(TIMEOUT);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [1:0]  instype_q, instype_d;
  logic [3:0]  wait_q, wait_d;
  logic        timeout_q, timeout_d;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;

  assign pc_plus4      = pc_q + 32'd4;
  assign branch_target = pc_q + 32'd8 + {{6{ir_q[23]}}, ir_q[23:0], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= 32'h0;
      instype_q <= 2'd0;
      wait_q    <= 4'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      instype_q <= instype_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  // The wait counter is zeroed on every transition into FETCH or MEM so each
  // handshake gets its own full budget; ready on the limit cycle still wins.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    instype_d = instype_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end else if (wait_q == TIMEOUT_L) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      S_DECODE: begin
        case (ir_q[27:26])
          2'b00: begin instype_d = 2'd1; state_d = S_EXEC; end
          2'b01: begin instype_d = 2'd2; state_d = S_EXEC; end
          2'b10: begin instype_d = 2'd3; state_d = S_EXEC; end
          default: begin instype_d = 2'd0; state_d = S_TRAP; end
        endcase
      end
      S_EXEC: begin
        case (instype_q)
          2'd1: state_d = S_WB;
          2'd2: begin
            state_d = S_MEM;
            wait_d  = 4'd0;
          end
          2'd3: begin
            pc_d    = branch_target;
            state_d = S_FETCH;
            wait_d  = 4'd0;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (ir_q[20]) begin
            state_d = S_WB;
          end else begin
            pc_d    = pc_plus4;
            state_d = S_FETCH;
            wait_d  = 4'd0;
          end
        end else if (wait_q == TIMEOUT_L) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      S_WB: begin
        pc_d    = pc_plus4;
        state_d = S_FETCH;
        wait_d  = 4'd0;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // imem_req is gated by rst_n because reset parks the FSM in FETCH.
  assign imem_req    = rst_n & (state_q == S_FETCH);
  assign dmem_req    = (state_q == S_MEM);
  assign dmem_we     = (state_q == S_MEM) & ~ir_q[20];
  assign reg_we      = (state_q == S_WB);
  assign link_we     = (state_q == S_EXEC) & (instype_q == 2'd3) & ir_q[24];
  assign link_data   = link_we ? pc_plus4 : 32'h0;
  assign halted      = (state_q == S_TRAP);
  assign timeout_err = (state_q == S_TRAP) & timeout_q;
  assign pc          = pc_q;
  assign ir          = ir_q;
  assign instype     = instype_q;
  assign state       = state_q;

endmodule

// File: tb/tb_inst_seq.sv
// Scoreboard bench for inst_seq: each scenario queues per-cycle stimulus with
// the outputs expected in that cycle, then drains the queue against the DUT.
module tb_inst_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        imem_req, dmem_req, dmem_we, reg_we, link_we;
  logic [31:0] link_data, pc, ir;
  logic [1:0]  instype;
  logic [2:0]  state;
  logic        halted, timeout_err;

  int tests = 0;
  int failures = 0;

  localparam logic [6:0] F_NONE  = 7'b0000000;
  localparam logic [6:0] F_IREQ  = 7'b1000000;
  localparam logic [6:0] F_DREQ  = 7'b0100000;
  localparam logic [6:0] F_DWE   = 7'b0010000;
  localparam logic [6:0] F_REGWE = 7'b0001000;
  localparam logic [6:0] F_LINK  = 7'b0000100;
  localparam logic [6:0] F_HALT  = 7'b0000010;
  localparam logic [6:0] F_TO    = 7'b0000001;

  typedef struct {
    logic [31:0] rdata;
    logic        iready;
    logic        dready;
    logic [75:0] e;
  } row_t;

  row_t q[$];

  inst_seq #(.RESET_PC(32'h0000_0000), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .imem_req(imem_req), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .reg_we(reg_we), .link_we(link_we), .link_data(link_data),
    .pc(pc), .ir(ir), .instype(instype), .state(state), .halted(halted),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [75:0] obs();
    return {state, imem_req, dmem_req, dmem_we, reg_we, link_we, halted,
            timeout_err, instype, pc, link_data};
  endfunction

  function automatic void push(input logic [31:0] rd, input logic ir_rdy,
                               input logic dr_rdy, input logic [2:0] st,
                               input logic [6:0] fl, input logic [1:0] ity,
                               input logic [31:0] p, input logic [31:0] ld);
    row_t r;
    r.rdata  = rd;
    r.iready = ir_rdy;
    r.dready = dr_rdy;
    r.e      = {st, fl, ity, p, ld};
    q.push_back(r);
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (obs() !== 76'h0 || ir !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_async: got %h ir %h expected 0", obs(), ir);
    end
    @(posedge clk);
    #2;
    tests++;
    if (obs() !== 76'h0 || ir !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_held: got %h ir %h expected 0", obs(), ir);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_data_op();
    int idx = 0;
    row_t r;
    push(32'hE0812003, 1, 0, 3'd0, F_IREQ,  2'd0, 32'h0, 32'h0);
    push(32'h0,        0, 0, 3'd1, F_NONE,  2'd0, 32'h0, 32'h0);
    push(32'h0,        0, 0, 3'd2, F_NONE,  2'd1, 32'h0, 32'h0);
    push(32'h0,        0, 0, 3'd4, F_REGWE, 2'd1, 32'h0, 32'h0);
    while (q.size() > 0) begin
      r = q.pop_front();
      imem_rdata = r.rdata; imem_ready = r.iready; dmem_ready = r.dready;
      #1;
      tests++;
      if (obs() !== r.e) begin
        failures++;
        $display("[TB] FAIL data_op row %0d: got %h expected %h", idx, obs(), r.e);
      end
      idx++;
      @(posedge clk); @(negedge clk);
    end
    tests++;
    if (ir !== 32'hE0812003 || pc !== 32'h4) begin
      failures++;
      $display("[TB] FAIL data_op_end: got ir %h pc %h expected E0812003 / 4", ir, pc);
    end
  endtask

  task automatic test_load();
    int idx = 0;
    row_t r;
    push(32'h0,        0, 0, 3'd0, F_IREQ,  2'd1, 32'h4, 32'h0);
    push(32'hE5912000, 1, 0, 3'd0, F_IREQ,  2'd1, 32'h4, 32'h0);
    push(32'h0,        0, 0, 3'd1, F_NONE,  2'd1, 32'h4, 32'h0);
    push(32'h0,        0, 0, 3'd2, F_NONE,  2'd2, 32'h4, 32'h0);
    for (int i = 0; i < 3; i++)
      push(32'h0,      0, 0, 3'd3, F_DREQ,  2'd2, 32'h4, 32'h0);
    push(32'h0,        0, 1, 3'd3, F_DREQ,  2'd2, 32'h4, 32'h0);
    push(32'h0,        0, 0, 3'd4, F_REGWE, 2'd2, 32'h4, 32'h0);
    while (q.size() > 0) begin
      r = q.pop_front();
      imem_rdata = r.rdata; imem_ready = r.iready; dmem_ready = r.dready;
      #1;
      tests++;
      if (obs() !== r.e) begin
        failures++;
        $display("[TB] FAIL load row %0d: got %h expected %h", idx, obs(), r.e);
      end
      idx++;
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_store();
    int idx = 0;
    row_t r;
    push(32'hE5812000, 1, 0, 3'd0, F_IREQ,         2'd2, 32'h8, 32'h0);
    push(32'h0,        0, 0, 3'd1, F_NONE,         2'd2, 32'h8, 32'h0);
    push(32'h0,        0, 0, 3'd2, F_NONE,         2'd2, 32'h8, 32'h0);
    push(32'h0,        0, 1, 3'd3, F_DREQ | F_DWE, 2'd2, 32'h8, 32'h0);
    push(32'h0,        0, 0, 3'd0, F_IREQ,         2'd2, 32'hC, 32'h0);
    while (q.size() > 0) begin
      r = q.pop_front();
      imem_rdata = r.rdata; imem_ready = r.iready; dmem_ready = r.dready;
      #1;
      tests++;
      if (obs() !== r.e) begin
        failures++;
        $display("[TB] FAIL store row %0d: got %h expected %h", idx, obs(), r.e);
      end
      idx++;
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_branch();
    int idx = 0;
    row_t r;
    // Forward branch 0xC -> 0x100 (offset 0x3B words), then BL to itself.
    push(32'hEA00003B, 1, 0, 3'd0, F_IREQ, 2'd2, 32'h0C,  32'h0);
    push(32'h0,        0, 0, 3'd1, F_NONE, 2'd2, 32'h0C,  32'h0);
    push(32'h0,        0, 0, 3'd2, F_NONE, 2'd3, 32'h0C,  32'h0);
    push(32'hEBFFFFFE, 1, 0, 3'd0, F_IREQ, 2'd3, 32'h100, 32'h0);
    push(32'h0,        0, 0, 3'd1, F_NONE, 2'd3, 32'h100, 32'h0);
    push(32'h0,        0, 0, 3'd2, F_LINK, 2'd3, 32'h100, 32'h104);
    push(32'h0,        0, 0, 3'd0, F_IREQ, 2'd3, 32'h100, 32'h0);
    while (q.size() > 0) begin
      r = q.pop_front();
      imem_rdata = r.rdata; imem_ready = r.iready; dmem_ready = r.dready;
      #1;
      tests++;
      if (obs() !== r.e) begin
        failures++;
        $display("[TB] FAIL branch row %0d: got %h expected %h", idx, obs(), r.e);
      end
      idx++;
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_undefined();
    int idx = 0;
    row_t r;
    push(32'hEC000000, 1, 0, 3'd0, F_IREQ, 2'd3, 32'h100, 32'h0);
    push(32'h0,        0, 0, 3'd1, F_NONE, 2'd3, 32'h100, 32'h0);
    for (int i = 0; i < 3; i++)
      push(32'hE0812003, 1, 1, 3'd5, F_HALT, 2'd0, 32'h100, 32'h0);
    while (q.size() > 0) begin
      r = q.pop_front();
      imem_rdata = r.rdata; imem_ready = r.iready; dmem_ready = r.dready;
      #1;
      tests++;
      if (obs() !== r.e) begin
        failures++;
        $display("[TB] FAIL undefined row %0d: got %h expected %h", idx, obs(), r.e);
      end
      idx++;
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    int idx = 0;
    row_t r;
    pulse_reset();
    for (int i = 0; i < 16; i++)
      push(32'h0, 0, 0, 3'd0, F_IREQ,        2'd0, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++)
      push(32'h0, 1, 1, 3'd5, F_HALT | F_TO, 2'd0, 32'h0, 32'h0);
    while (q.size() > 0) begin
      r = q.pop_front();
      imem_rdata = r.rdata; imem_ready = r.iready; dmem_ready = r.dready;
      #1;
      tests++;
      if (obs() !== r.e) begin
        failures++;
        $display("[TB] FAIL timeout row %0d: got %h expected %h", idx, obs(), r.e);
      end
      idx++;
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_ready_at_limit();
    int idx = 0;
    row_t r;
    pulse_reset();
    for (int i = 0; i < 15; i++)
      push(32'h0,      0, 0, 3'd0, F_IREQ,  2'd0, 32'h0, 32'h0);
    push(32'hE0812003, 1, 0, 3'd0, F_IREQ,  2'd0, 32'h0, 32'h0);
    push(32'h0,        0, 0, 3'd1, F_NONE,  2'd0, 32'h0, 32'h0);
    push(32'h0,        0, 0, 3'd2, F_NONE,  2'd1, 32'h0, 32'h0);
    push(32'h0,        0, 0, 3'd4, F_REGWE, 2'd1, 32'h0, 32'h0);
    push(32'h0,        0, 0, 3'd0, F_IREQ,  2'd1, 32'h4, 32'h0);
    while (q.size() > 0) begin
      r = q.pop_front();
      imem_rdata = r.rdata; imem_ready = r.iready; dmem_ready = r.dready;
      #1;
      tests++;
      if (obs() !== r.e) begin
        failures++;
        $display("[TB] FAIL ready_at_limit row %0d: got %h expected %h", idx, obs(), r.e);
      end
      idx++;
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_mem();
    int idx = 0;
    row_t r;
    push(32'hE5912000, 1, 0, 3'd0, F_IREQ, 2'd1, 32'h4, 32'h0);
    push(32'h0,        0, 0, 3'd1, F_NONE, 2'd1, 32'h4, 32'h0);
    push(32'h0,        0, 0, 3'd2, F_NONE, 2'd2, 32'h4, 32'h0);
    push(32'h0,        0, 0, 3'd3, F_DREQ, 2'd2, 32'h4, 32'h0);
    while (q.size() > 0) begin
      r = q.pop_front();
      imem_rdata = r.rdata; imem_ready = r.iready; dmem_ready = r.dready;
      #1;
      tests++;
      if (obs() !== r.e) begin
        failures++;
        $display("[TB] FAIL mid_mem row %0d: got %h expected %h", idx, obs(), r.e);
      end
      idx++;
      @(posedge clk); @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (obs() !== 76'h0 || ir !== 32'h0) begin
      failures++;
      $display("[TB] FAIL mid_mem_reset: got %h ir %h expected 0", obs(), ir);
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    push(32'h0, 0, 0, 3'd0, F_IREQ, 2'd0, 32'h0, 32'h0);
    push(32'h0, 0, 0, 3'd0, F_IREQ, 2'd0, 32'h0, 32'h0);
    while (q.size() > 0) begin
      r = q.pop_front();
      imem_rdata = r.rdata; imem_ready = r.iready; dmem_ready = r.dready;
      #1;
      tests++;
      if (obs() !== r.e) begin
        failures++;
        $display("[TB] FAIL mid_mem_restart row %0d: got %h expected %h", idx, obs(), r.e);
      end
      idx++;
      @(posedge clk); @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_data_op();
    test_load();
    test_store();
    test_branch();
    test_undefined();
    test_timeout();
    test_ready_at_limit();
    test_reset_mid_mem();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
